// File: rtl/lzc_norm_arb_pkg.sv
// Shared constants and width helpers for the arbitrated leading-zero normalizer.
package lzc_norm_arb_pkg;

  localparam int QM        = 12;
  localparam int QN        = 12;
  localparam int DEF_WIDTH = QM + QN;
  localparam int LZC_W     = 7;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int f_tagw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lzc_norm_arb_lzc_b.sv
// Leading-zero counter: returns WIDTH for an all-zero input.
module lzc_b
  import lzc_norm_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic [LZC_W-1:0] count
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    count = LZC_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = LZC_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/lzc_norm_arb.sv
// Round-robin arbitrated normalizer: NREQ requesters share one LZC and left shifter
// through a two-stage (A: operand, B: result) register pipeline.
module lzc_norm_arb
  import lzc_norm_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2,
  localparam int TAGW = f_tagw(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAGW-1:0]       out_tag,
  output logic [WIDTH-1:0]      out_norm,
  output logic [LZC_W-1:0]      out_lzc,
  output logic                  out_zero
);

  // Handshake: a beat moves when valid && ready on a rising edge; valid never waits
  // on ready, payload holds while valid && !ready, and the grant ignores out_ready.

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic [TAGW-1:0]  a_tag;
  logic [TAGW-1:0]  rr_ptr;
  logic [TAGW-1:0]  rr_next;
  logic [TAGW-1:0]  gidx;
  logic [NREQ-1:0]  grant;
  logic             found;
  logic [WIDTH-1:0] sel_data;
  logic             a_adv;
  logic             a_load;
  logic             xfer;
  logic [LZC_W-1:0] lzc;
  logic [WIDTH-1:0] norm;
  logic             zero;

  // Priority walks from rr_ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    gidx     = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] &&
            (TAGW'((int'(rr_ptr) + k) % NREQ) == TAGW'(i))) begin
          grant[i] = 1'b1;
          gidx     = TAGW'(i);
          sel_data = req_data[i*WIDTH +: WIDTH];
          found    = 1'b1;
        end
      end
    end
  end

  assign rr_next   = TAGW'((int'(gidx) + 1) % NREQ);
  assign a_adv     = a_valid && (!out_valid || out_ready);
  assign a_load    = !a_valid || a_adv;
  assign req_ready = grant & {NREQ{a_load}};
  assign xfer      = found && a_load;

  lzc_b #(.WIDTH(WIDTH)) u_lzc (
    .data  (a_data),
    .count (lzc)
  );

  assign norm = a_data << lzc;
  assign zero = (lzc == LZC_W'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_tag   <= '0;
      rr_ptr  <= '0;
    end else if (a_load) begin
      a_valid <= xfer;
      if (xfer) begin
        a_data <= sel_data;
        a_tag  <= gidx;
        rr_ptr <= rr_next;
      end
    end
  end

  // Stage B reloads in the same cycle it drains, so full throughput has no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_norm  <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
    end else if (a_adv) begin
      out_valid <= 1'b1;
      out_tag   <= a_tag;
      out_norm  <= norm;
      out_lzc   <= lzc;
      out_zero  <= zero;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
